// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store request, fixed wait states, byte-lane
// writes and a registered valid/ready response channel.
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LatInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] mem_q [DEPTH];

  logic            acc_err;
  logic [IdxW-1:0] acc_idx;

  // Decode of the latched request; only consulted in the final BUSY cycle.
  always_comb begin
    acc_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
    acc_idx = addr_q[IdxW+1:2];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[IdxW'(i)] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            write_q   <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            cnt_q     <= LatInit;
            req_ready <= 1'b0;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= '0;
            state_q   <= StResp;
            if (!acc_err) begin
              if (write_q) begin
                for (int i = 0; i < 4; i++) begin
                  if (be_q[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                  end
                end
              end else begin
                rsp_rdata <= mem_q[acc_idx];
              end
            end
          end
        end
        StResp: begin
          // Response held until taken; a new request can only be seen one cycle later.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a reference memory model pushes expected responses
// into a scoreboard queue at request acceptance; they are popped when the DUT responds.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LATENCY = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
  endtask

  // Called and returns at a negedge with req_ready expected high.
  // hold>0: keep rsp_ready low that many cycles while offering a junk request.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold);
    int   n;
    int   cyc;
    exp_t e;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_immediate", 32'(n), 32'd0);
    @(posedge clk);
    e.err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    e.rdata = '0;
    if (!e.err) begin
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
        end
      end else begin
        e.rdata = model_mem[a[7:2]];
      end
    end
    sb.push_back(e);
    @(negedge clk);
    // Junk store to word 0: would corrupt it if the DUT wrongly took it.
    req_valid = (hold > 0);
    req_write = 1'b1;
    req_addr  = 32'h0;
    req_wdata = 32'hFFFF_FFFF;
    req_be    = 4'hF;
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(LATENCY));
    check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    check_eq("rsp_rdata", rsp_rdata, e.rdata);
    check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rdata", rsp_rdata, e.rdata);
      check_eq("bp_err", 32'(rsp_err), 32'(e.err));
      check_eq("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check_eq("done_valid", 32'(rsp_valid), 32'd0);
    check_eq("done_req_ready", 32'(req_ready), 32'd1);
    check_eq("done_rdata", rsp_rdata, 32'd0);
    check_eq("done_err", 32'(rsp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);

    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, 0);
    do_req(1'b0, 32'h08, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h08, 32'h1122_3344, 4'b0101, 0);
    do_req(1'b0, 32'h08, 32'h0, 4'h0, 0);
    check_eq("be_merge_model", model_mem[2], 32'hDE22_BE44);
    do_req(1'b1, 32'h08, 32'hAAAA_AAAA, 4'b0000, 0);
    do_req(1'b0, 32'h08, 32'h0, 4'h0, 0);

    do_req(1'b1, 32'h00, 32'hCAFE_F00D, 4'hF, 0);
    do_req(1'b0, 32'h06, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h100, 32'h5555_5555, 4'hF, 0);
    do_req(1'b0, 32'h00, 32'h0, 4'h0, 0);

    // Backpressure with a junk request offered throughout, then an immediate follow-up.
    do_req(1'b0, 32'h08, 32'h0, 4'h0, 5);
    do_req(1'b0, 32'h00, 32'h0, 4'h0, 0);

    // Reset while BUSY on a store: nothing written, no response.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h04;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    check_eq("midrst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_model();
    for (int k = 0; k < 6; k++) begin
      check_eq("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    check_eq("midrst_req_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 32'h04, 32'h0, 4'h0, 0);
    do_req(1'b0, 32'h08, 32'h0, 4'h0, 0);

    for (int r = 0; r < 24; r++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 71)) * 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 2)));
    end
    do_req(1'b0, 32'h00, 32'h0, 4'h0, 0);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
